// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg
// Shared constants for the Wishbone GPIO bank: register word offsets,
// per-pin drive mode encoding and a byte-enable expansion helper.
package gpio_bank_pkg;

    localparam logic [2:0] GPIO_REG_DOUT   = 3'd0;
    localparam logic [2:0] GPIO_REG_DIN    = 3'd1;
    localparam logic [2:0] GPIO_REG_DIR    = 3'd2;
    localparam logic [2:0] GPIO_REG_MODE   = 3'd3;
    localparam logic [2:0] GPIO_REG_RISE   = 3'd4;
    localparam logic [2:0] GPIO_REG_FALL   = 3'd5;
    localparam logic [2:0] GPIO_REG_STATUS = 3'd6;
    localparam logic [2:0] GPIO_REG_TOGGLE = 3'd7;

    localparam logic GPIO_MODE_PP = 1'b0;
    localparam logic GPIO_MODE_OD = 1'b1;

    // Expand the four Wishbone byte selects into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        byte_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge
// Input synchroniser and edge detector for a bank of GPIO pins.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   pad       - raw asynchronous pad values
//   data_in   - synchronised pad values (last synchroniser stage)
//   rise      - per-pin rising edge seen on data_in this cycle
//   fall      - per-pin falling edge seen on data_in this cycle
module gpio_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pad,
    output logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] ARM_CNT = CW'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev;
    logic [CW-1:0]    arm_cnt;
    logic             armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev    <= '0;
            arm_cnt <= '0;
        end else begin
            sync_q[0] <= pad;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            // prev always follows data_in, including while disarmed, so a pin
            // that was already high at reset is not reported as a rise.
            prev <= sync_q[SYNC_STAGES-1];
            if (!armed) begin
                arm_cnt <= arm_cnt + CW'(1);
            end
        end
    end

    assign data_in = sync_q[SYNC_STAGES-1];
    assign armed   = (arm_cnt == ARM_CNT);
    assign rise    = armed ? (data_in & ~prev) : '0;
    assign fall    = armed ? (~data_in & prev) : '0;

endmodule

// File: rtl/gpio_bank_wb.sv
// gpio_bank_wb
// Wishbone-slave GPIO bank with per-pin direction, push-pull/open-drain
// mode, synchronised inputs and edge interrupts with W1C status.
// Ports:
//   i_clk, i_rst            - clock, synchronous active-high reset
//   i_wb_adr/dat/sel/we     - Wishbone word address, write data, byte selects, write
//   i_wb_cyc, i_wb_stb      - Wishbone cycle and strobe
//   o_wb_rdt, o_wb_ack      - registered read data (0 when not acking), acknowledge
//   i_gpio                  - asynchronous pad inputs
//   o_gpio, o_gpio_oe       - pad output values and output enables (1 = drive)
//   o_irq                   - level interrupt, high while any STATUS bit is set
// Handshake: a request is cyc & stb & ~ack; it is acked on the next cycle for
// exactly one cycle, so a held strobe acks every other cycle. Writes land on
// the same edge that raises ack, and read data is valid only while ack is high.
module gpio_bank_wb
    import gpio_bank_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [2:0]       i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic [3:0]       i_wb_sel,
    input  logic             i_wb_we,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    output logic [31:0]      o_wb_rdt,
    output logic             o_wb_ack,
    input  logic [WIDTH-1:0] i_gpio,
    output logic [WIDTH-1:0] o_gpio,
    output logic [WIDTH-1:0] o_gpio_oe,
    output logic             o_irq
);

    logic [WIDTH-1:0] dout, dir, mode, rise_en, fall_en, status;
    logic [WIDTH-1:0] data_in, rise, fall;
    logic [WIDTH-1:0] wmask, wdat, set_ev, clr, rd_val;
    logic [31:0]      be_mask, rd_word;
    logic             req, wr;
    logic             unused_bits;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (i_clk),
        .rst     (i_rst),
        .pad     (i_gpio),
        .data_in (data_in),
        .rise    (rise),
        .fall    (fall)
    );

    assign req     = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign wr      = req & i_wb_we;
    assign be_mask = byte_mask(i_wb_sel);
    assign wmask   = be_mask[WIDTH-1:0];
    assign wdat    = i_wb_dat[WIDTH-1:0];

    // Bits above WIDTH are simply not stored.
    assign unused_bits = ^{i_wb_dat, be_mask};

    assign set_ev = (rise & rise_en) | (fall & fall_en);
    assign clr    = (wr && (i_wb_adr == GPIO_REG_STATUS)) ? (wdat & wmask) : '0;

    always_comb begin
        rd_val = '0;
        case (i_wb_adr)
            GPIO_REG_DOUT:   rd_val = dout;
            GPIO_REG_DIN:    rd_val = data_in;
            GPIO_REG_DIR:    rd_val = dir;
            GPIO_REG_MODE:   rd_val = mode;
            GPIO_REG_RISE:   rd_val = rise_en;
            GPIO_REG_FALL:   rd_val = fall_en;
            GPIO_REG_STATUS: rd_val = status;
            default:         rd_val = '0;
        endcase
        rd_word = '0;
        rd_word[WIDTH-1:0] = rd_val;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
            dout     <= RESET_OUT;
            dir      <= RESET_DIR;
            mode     <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            status   <= '0;
        end else begin
            o_wb_ack <= req;
            o_wb_rdt <= req ? rd_word : '0;
            // New events are OR-ed in after the clear so a same-cycle set wins.
            status   <= (status & ~clr) | set_ev;
            if (wr) begin
                case (i_wb_adr)
                    GPIO_REG_DOUT:   dout    <= (dout    & ~wmask) | (wdat & wmask);
                    GPIO_REG_DIR:    dir     <= (dir     & ~wmask) | (wdat & wmask);
                    GPIO_REG_MODE:   mode    <= (mode    & ~wmask) | (wdat & wmask);
                    GPIO_REG_RISE:   rise_en <= (rise_en & ~wmask) | (wdat & wmask);
                    GPIO_REG_FALL:   fall_en <= (fall_en & ~wmask) | (wdat & wmask);
                    GPIO_REG_TOGGLE: dout    <= dout ^ (wdat & wmask);
                    default: ;
                endcase
            end
        end
    end

    // Open-drain pins never drive high: they pull low for 0 and release for 1.
    always_comb begin
        o_gpio    = '0;
        o_gpio_oe = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mode[i] == GPIO_MODE_OD) begin
                o_gpio[i]    = 1'b0;
                o_gpio_oe[i] = dir[i] & ~dout[i];
            end else begin
                o_gpio[i]    = dout[i];
                o_gpio_oe[i] = dir[i];
            end
        end
    end

    assign o_irq = |status;

endmodule

// File: tb/tb_gpio_bank_wb.sv
// tb_gpio_bank_wb
// Directed bench for gpio_bank_wb (WIDTH=8, SYNC_STAGES=2, RESET_OUT=0x3C,
// RESET_DIR=0x0F): register-access vector table plus hand-written sequences
// for edge latency, W1C/set collision, reset arming and reset during a cycle.
module tb_gpio_bank_wb;
    import gpio_bank_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  adr = '0;
    logic [31:0] dat = '0;
    logic [3:0]  sel = '0;
    logic        we  = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [31:0] rdt;
    logic        ack;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [2:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] exp_rdt;
        logic [7:0]  exp_gpio;
        logic [7:0]  exp_oe;
    } vec_t;

    vec_t vecs [21];

    gpio_bank_wb #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .RESET_OUT   (8'h3C),
        .RESET_DIR   (8'h0F)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wb_adr  (adr),
        .i_wb_dat  (dat),
        .i_wb_sel  (sel),
        .i_wb_we   (we),
        .i_wb_cyc  (cyc),
        .i_wb_stb  (stb),
        .o_wb_rdt  (rdt),
        .o_wb_ack  (ack),
        .i_gpio    (gpio_in),
        .o_gpio    (gpio_out),
        .o_gpio_oe (gpio_oe),
        .o_irq     (irq)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Driver / checker tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic w, output logic [31:0] r);
        int n;
        @(posedge clk); #1;
        adr = a; dat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 8);
        check("ack_seen", 32'(ack), 32'd1);
        r = rdt;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] r;
        wb_xfer(a, d, 4'hF, 1'b1, r);
    endtask

    task automatic check_read(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(a, 32'h0, 4'hF, 1'b0, r);
        exp_q.push_back(exp);
        check(name, r, exp_q.pop_front());
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [31:0] rst_exp [8];
    logic [31:0] r;

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdt", rdt, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_gpio", 32'(gpio_out), 32'h3C);
        check("rst_oe", 32'(gpio_oe), 32'h0F);
        rst_exp = '{32'h3C, 32'h00, 32'h0F, 32'h00, 32'h00, 32'h00, 32'h00, 32'h00};
        for (int i = 0; i < 8; i++) begin
            check_read("rst_read", 3'(i), rst_exp[i]);
        end

        gpio_in = 8'h5A;
        repeat (5) @(posedge clk);

        // Register table: adr, data, sel, we, exp_rdt (reads), exp_gpio, exp_oe
        vecs[0]  = '{GPIO_REG_DIR,    32'h0000_00FF, 4'hF, 1'b1, 32'h00, 8'h3C, 8'hFF};
        vecs[1]  = '{GPIO_REG_DOUT,   32'h0000_00A5, 4'hF, 1'b1, 32'h00, 8'hA5, 8'hFF};
        vecs[2]  = '{GPIO_REG_MODE,   32'h0000_000F, 4'hF, 1'b1, 32'h00, 8'hA0, 8'hFA};
        vecs[3]  = '{GPIO_REG_TOGGLE, 32'h0000_0001, 4'hF, 1'b1, 32'h00, 8'hA0, 8'hFB};
        vecs[4]  = '{GPIO_REG_DOUT,   32'h0,         4'hF, 1'b0, 32'hA4, 8'hA0, 8'hFB};
        vecs[5]  = '{GPIO_REG_TOGGLE, 32'h0,         4'hF, 1'b0, 32'h00, 8'hA0, 8'hFB};
        vecs[6]  = '{GPIO_REG_MODE,   32'h0,         4'hF, 1'b0, 32'h0F, 8'hA0, 8'hFB};
        vecs[7]  = '{GPIO_REG_DOUT,   32'hFFFF_FF12, 4'h0, 1'b1, 32'h00, 8'hA0, 8'hFB};
        vecs[8]  = '{GPIO_REG_DOUT,   32'h0000_00FF, 4'h2, 1'b1, 32'h00, 8'hA0, 8'hFB};
        vecs[9]  = '{GPIO_REG_DOUT,   32'h0,         4'hF, 1'b0, 32'hA4, 8'hA0, 8'hFB};
        vecs[10] = '{GPIO_REG_MODE,   32'hFFFF_FF00, 4'hF, 1'b1, 32'h00, 8'hA4, 8'hFF};
        vecs[11] = '{GPIO_REG_MODE,   32'h0,         4'hF, 1'b0, 32'h00, 8'hA4, 8'hFF};
        vecs[12] = '{GPIO_REG_DIR,    32'h0000_0033, 4'hF, 1'b1, 32'h00, 8'hA4, 8'h33};
        vecs[13] = '{GPIO_REG_TOGGLE, 32'h0000_00FF, 4'hF, 1'b1, 32'h00, 8'h5B, 8'h33};
        vecs[14] = '{GPIO_REG_DOUT,   32'h0,         4'hF, 1'b0, 32'h5B, 8'h5B, 8'h33};
        vecs[15] = '{GPIO_REG_DIN,    32'h0,         4'hF, 1'b0, 32'h5A, 8'h5B, 8'h33};
        vecs[16] = '{GPIO_REG_RISE,   32'h0000_0100, 4'h3, 1'b1, 32'h00, 8'h5B, 8'h33};
        vecs[17] = '{GPIO_REG_RISE,   32'h0,         4'hF, 1'b0, 32'h00, 8'h5B, 8'h33};
        vecs[18] = '{GPIO_REG_DIR,    32'h0,         4'hF, 1'b0, 32'h33, 8'h5B, 8'h33};
        vecs[19] = '{GPIO_REG_MODE,   32'h0000_0030, 4'hF, 1'b1, 32'h00, 8'h4B, 8'h23};
        vecs[20] = '{GPIO_REG_MODE,   32'h0,         4'hF, 1'b0, 32'h30, 8'h4B, 8'h23};

        for (int i = 0; i < 21; i++) begin
            wb_xfer(vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].we, r);
            if (!vecs[i].we) begin
                exp_q.push_back(vecs[i].exp_rdt);
                check($sformatf("vec%0d_rdt", i), r, exp_q.pop_front());
            end
            check($sformatf("vec%0d_gpio", i), 32'(gpio_out), 32'(vecs[i].exp_gpio));
            check($sformatf("vec%0d_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
        end
        @(posedge clk); #1;
        check("rdt_idle", rdt, 32'h0);
        check("ack_idle", 32'(ack), 32'd0);

        // Rising edge latency: pad change in cycle t, STATUS/irq at t+3
        wb_write(GPIO_REG_RISE, 32'h01);
        @(posedge clk); #1;
        gpio_in = 8'h5B;
        @(posedge clk); #1;
        check("rise_irq_t1", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check("rise_irq_t2", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check("rise_irq_t3", 32'(irq), 32'd1);
        check_read("rise_status", GPIO_REG_STATUS, 32'h01);
        wb_write(GPIO_REG_STATUS, 32'h01);
        @(posedge clk); #1;
        check("w1c_irq", 32'(irq), 32'd0);
        check_read("w1c_status", GPIO_REG_STATUS, 32'h00);

        // Pending bit survives disabling RISE_EN
        gpio_in = 8'h5A;
        repeat (4) @(posedge clk);
        #1;
        gpio_in = 8'h5B;
        repeat (5) @(posedge clk);
        wb_write(GPIO_REG_RISE, 32'h00);
        check_read("pend_status", GPIO_REG_STATUS, 32'h01);
        check("pend_irq", 32'(irq), 32'd1);
        wb_write(GPIO_REG_STATUS, 32'h01);
        @(posedge clk); #1;
        check("pend_clr_irq", 32'(irq), 32'd0);

        // Falling-edge set coincides with a W1C of the same bit
        wb_write(GPIO_REG_FALL, 32'h02);
        @(posedge clk); #1;
        gpio_in = 8'h59;
        @(posedge clk);
        wb_write(GPIO_REG_STATUS, 32'h02);
        check_read("collide_status", GPIO_REG_STATUS, 32'h02);
        check("collide_irq", 32'(irq), 32'd1);
        wb_write(GPIO_REG_STATUS, 32'h02);
        check_read("collide_clr", GPIO_REG_STATUS, 32'h00);

        // Pins held high through reset produce no rise after arming
        gpio_in = 8'hFF;
        repeat (3) @(posedge clk);
        do_reset();
        wb_write(GPIO_REG_RISE, 32'hFF);
        repeat (8) @(posedge clk);
        #1;
        check("arm_irq", 32'(irq), 32'd0);
        check_read("arm_status", GPIO_REG_STATUS, 32'h00);
        check_read("arm_din", GPIO_REG_DIN, 32'hFF);

        // Reset during a pending write: no ack, registers at reset values
        wb_write(GPIO_REG_DIR, 32'h77);
        wb_write(GPIO_REG_DOUT, 32'h11);
        @(posedge clk); #1;
        adr = GPIO_REG_DIR; dat = 32'hFF; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("rst_midcycle_ack", 32'(ack), 32'd0);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
        check_read("rst_midcycle_dir", GPIO_REG_DIR, 32'h0F);
        check_read("rst_midcycle_dout", GPIO_REG_DOUT, 32'h3C);
        check("rst_midcycle_oe", 32'(gpio_oe), 32'h0F);

        // Held strobe acks on alternate cycles
        @(posedge clk); #1;
        adr = GPIO_REG_DOUT; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("held_ack%0d", k), 32'(ack), (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("held_rdt%0d", k), rdt, (k % 2 == 0) ? 32'h3C : 32'h0);
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        check("held_release_ack", 32'(ack), 32'd0);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
